// File: rtl/graphene_ref_scheduler.sv
// graphene_ref_scheduler: sequences host row activations into a Graphene-style
// aggressor tracker, captures aggressor rows flagged by the tracker into a small
// victim FIFO, and issues targeted refreshes to the two neighbouring rows of each
// captured aggressor. A free-running refresh-window counter periodically resets
// the tracker between activations.
//
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   act_valid/act_ready/act_addr host activation handshake and row
//   trk_act_addr                 row currently presented to the tracker
//   trk_reset                    tracker synchronous reset (window restart or reset_n low)
//   trk_ref_read_en              tracker park / alert-clear strobe
//   trk_alert, trk_ref_addr      tracker alert and the aggressor row it reports
//   trr_valid/trr_ready/trr_row  targeted-refresh request handshake and victim row
//   alert_count                  saturating count of captured aggressors
module graphene_ref_scheduler #(
  parameter int unsigned             ADDRESS_SIZE  = 16,
  parameter int unsigned             FIFO_DEPTH    = 4,
  parameter logic [31:0]             WINDOW_CYCLES = 32'd1000000,
  parameter logic [ADDRESS_SIZE-1:0] ROW_MAX       = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    act_valid,
  output logic                    act_ready,
  input  logic [ADDRESS_SIZE-1:0] act_addr,
  output logic [ADDRESS_SIZE-1:0] trk_act_addr,
  output logic                    trk_reset,
  output logic                    trk_ref_read_en,
  input  logic                    trk_alert,
  input  logic [ADDRESS_SIZE-1:0] trk_ref_addr,
  output logic                    trr_valid,
  input  logic                    trr_ready,
  output logic [ADDRESS_SIZE-1:0] trr_row,
  output logic [15:0]             alert_count
);

  localparam int unsigned             PtrW   = $clog2(FIFO_DEPTH);
  localparam logic [ADDRESS_SIZE-1:0] RowOne = ADDRESS_SIZE'(1);

  typedef enum logic [2:0] {
    StSettle,
    StPark,
    StAct,
    StD1,
    StD2,
    StCheck,
    StWinRst
  } state_e;

  typedef enum logic [1:0] {
    IsIdle,
    IsLow,
    IsHigh
  } iss_e;

  state_e                  state_q, state_d;
  iss_e                    iss_q, iss_d;
  logic [ADDRESS_SIZE-1:0] act_addr_q, act_addr_d;
  logic [31:0]             win_cnt_q, win_cnt_d;
  logic                    win_pending_q, win_pending_d;
  logic [15:0]             alert_cnt_q, alert_cnt_d;
  logic [ADDRESS_SIZE-1:0] trr_row_q, trr_row_d;
  logic [PtrW:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]           rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_SIZE-1:0] fifo_mem_q [FIFO_DEPTH];

  logic                    act_accept;
  logic                    alert_capture;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    win_hit;
  logic [ADDRESS_SIZE-1:0] head_row;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                      (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
  assign head_row   = fifo_mem_q[rd_ptr_q[PtrW-1:0]];

  // ---------------------------------------------------------------------------
  // Sequencing FSM: next state and tracker-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    act_ready       = 1'b0;
    act_accept      = 1'b0;
    trk_ref_read_en = 1'b0;
    alert_capture   = 1'b0;
    act_addr_d      = act_addr_q;

    unique case (state_q)
      StSettle: begin
        trk_ref_read_en = 1'b1;
        state_d         = StPark;
      end
      StPark: begin
        // Pending window restart and a full FIFO both block new activations,
        // so every accepted activation has a free FIFO slot for its CHECK.
        act_ready       = !fifo_full && !win_pending_q;
        act_accept      = act_valid && act_ready;
        trk_ref_read_en = !act_accept;
        if (act_accept) begin
          act_addr_d = act_addr;
          state_d    = StAct;
        end else if (win_pending_q) begin
          state_d = StWinRst;
        end
      end
      StAct:    state_d = StD1;
      StD1:     state_d = StD2;
      StD2:     state_d = StCheck;
      StCheck: begin
        // read_en in this cycle also clears the tracker alert being captured.
        trk_ref_read_en = 1'b1;
        alert_capture   = trk_alert;
        state_d         = StPark;
      end
      StWinRst: state_d = StSettle;
      default:  state_d = StSettle;
    endcase
  end

  assign trk_reset    = (state_q == StWinRst) || !reset_n;
  assign trk_act_addr = act_addr_q;

  // ---------------------------------------------------------------------------
  // Refresh-window counter and alert counter
  // ---------------------------------------------------------------------------
  assign win_hit = (win_cnt_q == WINDOW_CYCLES - 32'd1);

  always_comb begin
    win_cnt_d     = win_hit ? 32'd0 : win_cnt_q + 32'd1;
    win_pending_d = win_pending_q;
    // A new window boundary wins over the clear from the WIN_RST just leaving.
    if (win_hit) begin
      win_pending_d = 1'b1;
    end else if (state_q == StWinRst) begin
      win_pending_d = 1'b0;
    end
  end

  always_comb begin
    alert_cnt_d = alert_cnt_q;
    if (alert_capture && (alert_cnt_q != 16'hFFFF)) begin
      alert_cnt_d = alert_cnt_q + 16'd1;
    end
  end

  assign alert_count = alert_cnt_q;

  // ---------------------------------------------------------------------------
  // Victim FIFO pointers
  // ---------------------------------------------------------------------------
  assign fifo_push = alert_capture && !fifo_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q[PtrW-1:0]] <= trk_ref_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh issuer: works on the FIFO head in place and pops it only once the
  // last neighbour request for that aggressor has been accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    iss_d     = iss_q;
    trr_row_d = trr_row_q;
    fifo_pop  = 1'b0;

    unique case (iss_q)
      IsIdle: begin
        if (!fifo_empty) begin
          if (head_row != '0) begin
            iss_d     = IsLow;
            trr_row_d = head_row - RowOne;
          end else if (head_row != ROW_MAX) begin
            iss_d     = IsHigh;
            trr_row_d = head_row + RowOne;
          end else begin
            fifo_pop = 1'b1;
          end
        end
      end
      IsLow: begin
        if (trr_ready) begin
          if (head_row != ROW_MAX) begin
            iss_d     = IsHigh;
            trr_row_d = head_row + RowOne;
          end else begin
            iss_d    = IsIdle;
            fifo_pop = 1'b1;
          end
        end
      end
      IsHigh: begin
        if (trr_ready) begin
          iss_d    = IsIdle;
          fifo_pop = 1'b1;
        end
      end
      default: iss_d = IsIdle;
    endcase
  end

  assign trr_valid = (iss_q != IsIdle);
  assign trr_row   = trr_row_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StSettle;
      iss_q         <= IsIdle;
      act_addr_q    <= '0;
      win_cnt_q     <= 32'd0;
      win_pending_q <= 1'b0;
      alert_cnt_q   <= 16'd0;
      trr_row_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      iss_q         <= iss_d;
      act_addr_q    <= act_addr_d;
      win_cnt_q     <= win_cnt_d;
      win_pending_q <= win_pending_d;
      alert_cnt_q   <= alert_cnt_d;
      trr_row_q     <= trr_row_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_graphene_ref_scheduler.sv
// Self-checking bench for graphene_ref_scheduler (16-bit rows, 4-entry FIFO,
// 64-cycle refresh window). Directed scenarios plus a randomized run checked
// against a transaction-level model of the scheduler.
module tb_graphene_ref_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        act_valid;
  logic        act_ready;
  logic [15:0] act_addr;
  logic [15:0] trk_act_addr;
  logic        trk_reset;
  logic        trk_ref_read_en;
  logic        trk_alert;
  logic [15:0] trk_ref_addr;
  logic        trr_valid;
  logic        trr_ready;
  logic [15:0] trr_row;
  logic [15:0] alert_count;

  int          checks;
  int          errors;
  int          cyc;
  logic [15:0] got_rows[$];

  graphene_ref_scheduler #(
    .ADDRESS_SIZE  (16),
    .FIFO_DEPTH    (4),
    .WINDOW_CYCLES (32'd64),
    .ROW_MAX       (16'hFFFF)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .act_valid       (act_valid),
    .act_ready       (act_ready),
    .act_addr        (act_addr),
    .trk_act_addr    (trk_act_addr),
    .trk_reset       (trk_reset),
    .trk_ref_read_en (trk_ref_read_en),
    .trk_alert       (trk_alert),
    .trk_ref_addr    (trk_ref_addr),
    .trr_valid       (trr_valid),
    .trr_ready       (trr_ready),
    .trr_row         (trr_row),
    .alert_count     (alert_count)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: cycle 0 is the first cycle after release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 after release.
  task automatic apply_reset();
    reset_n      = 1'b0;
    act_valid    = 1'b0;
    act_addr     = 16'h0;
    trk_alert    = 1'b0;
    trk_ref_addr = 16'h0;
    trr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Accepts one activation; drives the tracker alert in its CHECK cycle (t+4).
  // Returns at the start of cycle t+5.
  task automatic do_activation(input logic [15:0] addr, input logic alert,
                               input logic [15:0] ref_addr);
    bit ok = 1'b0;
    act_valid = 1'b1;
    act_addr  = addr;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (act_ready === 1'b1) ok = 1'b1;
      tick();
    end
    act_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL act_accept_timeout: act_ready got %b required 1 within 200 cycles",
               act_ready);
      return;
    end
    repeat (3) tick();
    trk_alert    = alert;
    trk_ref_addr = ref_addr;
    tick();
    trk_alert = 1'b0;
  endtask

  task automatic collect_rows(input int n);
    got_rows.delete();
    trr_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (trr_valid === 1'b1) got_rows.push_back(trr_row);
      tick();
    end
    trr_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    act_valid = 1'b0; act_addr = 16'h0; trk_alert = 1'b0; trk_ref_addr = 16'h0;
    trr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({act_ready, trk_reset, trk_ref_read_en, trr_valid} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_ctrl: {ready,trk_reset,read_en,trr_valid} got %b required 0110",
               {act_ready, trk_reset, trk_ref_read_en, trr_valid});
    end
    checks++;
    if ({trr_row, alert_count, trk_act_addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: trr_row/alert_count/trk_act_addr got %h/%h/%h required 0",
               trr_row, alert_count, trk_act_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({act_ready, trk_reset, trk_ref_read_en} !== 3'b001) begin
      errors++;
      $display("FAIL reset_first_cycle_settle: {ready,trk_reset,read_en} got %b required 001",
               {act_ready, trk_reset, trk_ref_read_en});
    end
    tick();
    @(negedge clk);
    checks++;
    if (act_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_second_cycle_ready: act_ready got %b required 1", act_ready);
    end
  endtask

  task automatic test_single_activation();
    bit ok = 1'b0;
    apply_reset();
    act_valid = 1'b1;
    act_addr  = 16'h0010;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (act_ready === 1'b1) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok || trk_ref_read_en !== 1'b0) begin
      errors++;
      $display("FAIL single_t_read_en: accepted %0d read_en got %b required 0", ok,
               trk_ref_read_en);
    end
    tick();
    act_valid = 1'b0;
    act_addr  = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (trk_act_addr !== 16'h0010) begin
      errors++;
      $display("FAIL single_t1_addr: trk_act_addr got %h required 0010", trk_act_addr);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (trk_ref_read_en !== 1'b1 || trk_act_addr !== 16'h0010) begin
      errors++;
      $display("FAIL single_t4_check: read_en/addr got %b/%h required 1/0010",
               trk_ref_read_en, trk_act_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (act_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_t5_ready: act_ready got %b required 1", act_ready);
    end
  endtask

  task automatic test_alert_capture();
    bit seen = 1'b0;
    apply_reset();
    do_activation(16'h0040, 1'b1, 16'h1234);
    @(negedge clk);
    checks++;
    if (alert_count !== 16'd1) begin
      errors++;
      $display("FAIL alert_count: got %0d required 1", alert_count);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      if (trr_valid === 1'b1) seen = 1'b1;
      else begin tick(); @(negedge clk); end
    end
    checks++;
    if (!seen || trr_row !== 16'h1233) begin
      errors++;
      $display("FAIL alert_first_row: valid %0d trr_row got %h required 1233", seen, trr_row);
    end
    tick();
    @(negedge clk);
    checks++;
    if (trr_valid !== 1'b1 || trr_row !== 16'h1233) begin
      errors++;
      $display("FAIL alert_row_hold: valid/row got %b/%h required 1/1233", trr_valid, trr_row);
    end
    trr_ready = 1'b1;
    tick();
    trr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (trr_valid !== 1'b1 || trr_row !== 16'h1235) begin
      errors++;
      $display("FAIL alert_second_row: valid/row got %b/%h required 1/1235", trr_valid, trr_row);
    end
    trr_ready = 1'b1;
    tick();
    trr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (trr_valid !== 1'b0) begin
      errors++;
      $display("FAIL alert_done: trr_valid got %b required 0", trr_valid);
    end
  endtask

  task automatic test_row_boundaries();
    apply_reset();
    do_activation(16'h0200, 1'b1, 16'h0000);
    collect_rows(10);
    checks++;
    if (got_rows.size() != 1 || (got_rows.size() > 0 && got_rows[0] !== 16'h0001)) begin
      errors++;
      $display("FAIL boundary_row0: %0d requests, first %h; required 1 request 0001",
               got_rows.size(), (got_rows.size() > 0) ? got_rows[0] : 16'hxxxx);
    end
    do_activation(16'h0300, 1'b1, 16'hFFFF);
    collect_rows(10);
    checks++;
    if (got_rows.size() != 1 || (got_rows.size() > 0 && got_rows[0] !== 16'hFFFE)) begin
      errors++;
      $display("FAIL boundary_rowmax: %0d requests, first %h; required 1 request FFFE",
               got_rows.size(), (got_rows.size() > 0) ? got_rows[0] : 16'hxxxx);
    end
  endtask

  task automatic test_fifo_full();
    int bad = 0;
    apply_reset();
    do_activation(16'h0011, 1'b1, 16'h0000);
    for (int k = 0; k < 3; k++) do_activation(16'($urandom), 1'b1, 16'h0100 + 16'(k));
    act_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (act_ready !== 1'b0) bad++;
      tick();
    end
    act_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fifo_full_blocks: act_ready high in %0d of 8 cycles, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (trr_valid !== 1'b1 || trr_row !== 16'h0001 || alert_count !== 16'd4) begin
      errors++;
      $display("FAIL fifo_full_head: valid/row/count got %b/%h/%0d required 1/0001/4",
               trr_valid, trr_row, alert_count);
    end
    trr_ready = 1'b1;
    tick();
    trr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (act_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full_release: act_ready got %b required 1", act_ready);
    end
  endtask

  task automatic test_window_reset();
    int   pulses[4];
    int   after_pulse = 0;
    logic p1_ren = 1'b0, p2_ren = 1'b0, p1_rdy = 1'b0;
    for (int w = 0; w < 4; w++) pulses[w] = 0;
    apply_reset();
    do_activation(16'h0500, 1'b1, 16'h0100);
    act_valid = 1'b1;
    while (cyc < 256) begin
      act_addr = 16'($urandom);
      @(negedge clk);
      if (after_pulse == 1) begin
        checks++;
        if ({trk_reset, trk_ref_read_en, act_ready} !== 3'b010) begin
          errors++;
          $display("FAIL window_settle cyc %0d: {trk_reset,read_en,ready} got %b required 010",
                   cyc, {trk_reset, trk_ref_read_en, act_ready});
        end
        after_pulse = 2;
      end else if (after_pulse == 2) begin
        checks++;
        if (act_ready !== 1'b1) begin
          errors++;
          $display("FAIL window_park cyc %0d: act_ready got %b required 1", cyc, act_ready);
        end
        after_pulse = 0;
      end
      if (trk_reset === 1'b1) begin
        pulses[cyc / 64]++;
        checks++;
        // PARK with a pending window: read_en high, ready low, and preceded by
        // another read_en-high cycle (CHECK or PARK), unlike CHECK after D2.
        if (!(p1_ren && p2_ren && !p1_rdy)) begin
          errors++;
          $display("FAIL window_from_park cyc %0d: prev read_en %b%b prev ready %b required 11/0",
                   cyc, p2_ren, p1_ren, p1_rdy);
        end
        after_pulse = 1;
      end
      p2_ren = p1_ren;
      p1_ren = trk_ref_read_en;
      p1_rdy = act_ready;
      tick();
    end
    act_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (pulses[w] != ((w == 0) ? 0 : 1)) begin
        errors++;
        $display("FAIL window_pulse_count w%0d: got %0d required %0d", w, pulses[w],
                 (w == 0) ? 0 : 1);
      end
    end
    @(negedge clk);
    checks++;
    if (trr_valid !== 1'b1 || trr_row !== 16'h00FF || alert_count !== 16'd1) begin
      errors++;
      $display("FAIL window_fifo_kept: valid/row/count got %b/%h/%0d required 1/00FF/1",
               trr_valid, trr_row, alert_count);
    end
  endtask

  task automatic test_async_reset();
    bit ok = 1'b0;
    apply_reset();
    act_valid = 1'b1;
    act_addr  = 16'h0777;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (act_ready === 1'b1) ok = 1'b1;
      tick();
    end
    act_valid    = 1'b0;
    trk_alert    = 1'b1;
    trk_ref_addr = 16'h0ABC;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || {trk_reset, trk_ref_read_en, act_ready, trr_valid} !== 4'b1100 ||
        trk_act_addr !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_now: accepted %0d {rst,ren,rdy,vld} %b addr %h required 1100/0000",
               ok, {trk_reset, trk_ref_read_en, act_ready, trr_valid}, trk_act_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    trk_alert = 1'b0;
    @(negedge clk);
    checks++;
    if ({trk_reset, trk_ref_read_en, act_ready} !== 3'b010) begin
      errors++;
      $display("FAIL async_reset_settle: {trk_reset,read_en,ready} got %b required 010",
               {trk_reset, trk_ref_read_en, act_ready});
    end
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (trr_valid !== 1'b0 || alert_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_no_push: trr_valid/alert_count got %b/%0d required 0/0",
               trr_valid, alert_count);
    end
  endtask

  // Transaction-level model: activation age, window-restart sequence, a queue
  // of captured aggressors and the list of neighbour rows still to be issued.
  task automatic test_random();
    int          act_age = 0;
    int          win_seq = 2;  // 0 none, 1 tracker reset cycle, 2 settle cycle
    int          old_ws;
    int          ncyc = 0;
    bit          pending = 1'b0;
    bit          exp_ready, exp_ren, exp_rst, exp_valid, accept;
    logic [15:0] exp_addr = 16'h0;
    int          exp_alerts = 0;
    logic [15:0] fifo[$];
    logic [15:0] cur[$];
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      act_valid = ($urandom_range(9) < 7);
      act_addr  = 16'($urandom);
      trk_alert = 1'($urandom_range(1));
      case ($urandom_range(7))
        0:       trk_ref_addr = 16'h0000;
        1:       trk_ref_addr = 16'hFFFF;
        default: trk_ref_addr = 16'($urandom);
      endcase
      trr_ready = 1'($urandom_range(1));
      exp_ready = (act_age == 0) && (win_seq == 0) && (fifo.size() < 4) && !pending;
      accept    = act_valid && exp_ready;
      exp_ren   = (win_seq == 2) || (act_age == 4) || (act_age == 0 && win_seq == 0 && !accept);
      exp_rst   = (win_seq == 1);
      exp_valid = (cur.size() > 0);
      @(negedge clk);
      checks++;
      if ({act_ready, trk_ref_read_en, trk_reset, trr_valid} !==
          {exp_ready, exp_ren, exp_rst, exp_valid}) begin
        errors++;
        $display("FAIL rnd_ctrl cyc %0d: {rdy,ren,rst,vld} got %b required %b", ncyc,
                 {act_ready, trk_ref_read_en, trk_reset, trr_valid},
                 {exp_ready, exp_ren, exp_rst, exp_valid});
      end
      checks++;
      if (trk_act_addr !== exp_addr || alert_count !== 16'(exp_alerts)) begin
        errors++;
        $display("FAIL rnd_data cyc %0d: addr/count got %h/%0d required %h/%0d", ncyc,
                 trk_act_addr, alert_count, exp_addr, exp_alerts);
      end
      if (exp_valid) begin
        checks++;
        if (trr_row !== cur[0]) begin
          errors++;
          $display("FAIL rnd_trr_row cyc %0d: got %h required %h", ncyc, trr_row, cur[0]);
        end
      end
      // Issuer and FIFO advance.
      if (cur.size() > 0) begin
        if (trr_ready) begin
          void'(cur.pop_front());
          if (cur.size() == 0) void'(fifo.pop_front());
        end
      end else if (fifo.size() > 0) begin
        if (fifo[0] != 16'h0000) cur.push_back(fifo[0] - 16'h1);
        if (fifo[0] != 16'hFFFF) cur.push_back(fifo[0] + 16'h1);
      end
      if (act_age == 4 && trk_alert) begin
        fifo.push_back(trk_ref_addr);
        if (exp_alerts < 65535) exp_alerts++;
      end
      // Sequencer advance.
      old_ws = win_seq;
      if (win_seq == 1)       win_seq = 2;
      else if (win_seq == 2)  win_seq = 0;
      else if (act_age == 4)  act_age = 0;
      else if (act_age > 0)   act_age++;
      else if (accept) begin
        act_age  = 1;
        exp_addr = act_addr;
      end else if (pending)   win_seq = 1;
      if (old_ws == 1) pending = 1'b0;
      ncyc++;
      if (ncyc % 64 == 0) pending = 1'b1;
      tick();
    end
    act_valid = 1'b0;
    trr_ready = 1'b0;
    trk_alert = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_activation();
    test_alert_capture();
    test_row_boundaries();
    test_fifo_full();
    test_window_reset();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
             checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
